// File: rtl/axi_tb_ctrl.sv
// axi_tb_ctrl: harness controller that sequences DUT reset, gates the run
// phase, counts AXI handshakes and decides end-of-test (pass/timeout/stall).
module axi_tb_ctrl #(
  parameter int unsigned NUM_CH         = 5,
  parameter int unsigned RST_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 100,
  parameter int unsigned IDLE_CYCLES    = 16,
  parameter int unsigned STALL_CYCLES   = 64,
  parameter int unsigned CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              test_done,
  input  logic [NUM_CH-1:0] ch_valid,
  input  logic [NUM_CH-1:0] ch_ready,
  output logic              dut_rst,
  output logic              run,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  xfer_cnt,
  output logic              finish,
  output logic [1:0]        status,
  output logic [NUM_CH-1:0] stall_ch
);

  localparam int unsigned SC_W = $clog2(STALL_CYCLES + 1);
  localparam int unsigned IC_W = $clog2(IDLE_CYCLES + 1);
  localparam int unsigned RC_W = $clog2(RST_CYCLES + 1);
  localparam int unsigned PC_W = $clog2(NUM_CH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state;
  logic [RC_W-1:0]   rst_cnt;
  logic [IC_W-1:0]   idle_cnt;
  logic [SC_W-1:0]   stall_cnt [NUM_CH];

  logic [PC_W-1:0]   xfer_pc;
  logic [NUM_CH-1:0] stall_hit;
  logic [NUM_CH-1:0] stall_first;
  logic              found;
  logic              all_idle;
  logic [CNT_W:0]    cyc_sum;
  logic [CNT_W:0]    xfer_sum;
  logic [CNT_W-1:0]  cycle_next;
  logic [CNT_W-1:0]  xfer_next;

  // Handshake popcount, stall detection with lowest-index pick, saturating sums
  always_comb begin
    xfer_pc     = '0;
    stall_hit   = '0;
    stall_first = '0;
    found       = 1'b0;
    all_idle    = (ch_valid == '0);
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ch_valid[i] && ch_ready[i])
        xfer_pc = xfer_pc + PC_W'(1);
      if (ch_valid[i] && !ch_ready[i] && (stall_cnt[i] == SC_W'(STALL_CYCLES - 1)))
        stall_hit[i] = 1'b1;
    end
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (stall_hit[i] && !found) begin
        stall_first[i] = 1'b1;
        found          = 1'b1;
      end
    end
    cyc_sum    = {1'b0, cycle_cnt} + (CNT_W+1)'(1);
    xfer_sum   = {1'b0, xfer_cnt} + (CNT_W+1)'(xfer_pc);
    cycle_next = cyc_sum[CNT_W]  ? '1 : cyc_sum[CNT_W-1:0];
    xfer_next  = xfer_sum[CNT_W] ? '1 : xfer_sum[CNT_W-1:0];
  end

  // Test sequencing FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      dut_rst   <= 1'b1;
      run       <= 1'b0;
      cycle_cnt <= '0;
      xfer_cnt  <= '0;
      finish    <= 1'b0;
      status    <= 2'b00;
      stall_ch  <= '0;
      rst_cnt   <= '0;
      idle_cnt  <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) stall_cnt[i] <= '0;
    end else begin
      finish <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_RESET;
            rst_cnt   <= '0;
            cycle_cnt <= '0;
            xfer_cnt  <= '0;
            idle_cnt  <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) stall_cnt[i] <= '0;
          end
        end
        S_RESET: begin
          if (rst_cnt == RC_W'(RST_CYCLES - 1)) begin
            state   <= S_RUN;
            dut_rst <= 1'b0;
            run     <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt + RC_W'(1);
          end
        end
        S_RUN, S_DRAIN: begin
          cycle_cnt <= cycle_next;
          xfer_cnt  <= xfer_next;
          for (int unsigned i = 0; i < NUM_CH; i++)
            stall_cnt[i] <= (ch_valid[i] && !ch_ready[i]) ? stall_cnt[i] + SC_W'(1) : '0;
          if (state == S_DRAIN)
            idle_cnt <= all_idle ? idle_cnt + IC_W'(1) : '0;
          // Termination checks ordered stall > timeout > pass; any of them
          // also overrides a concurrent test_done
          if (|stall_hit) begin
            state    <= S_DONE;
            run      <= 1'b0;
            finish   <= 1'b1;
            status   <= 2'b11;
            stall_ch <= stall_first;
          end else if (cycle_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state  <= S_DONE;
            run    <= 1'b0;
            finish <= 1'b1;
            status <= 2'b10;
          end else if ((state == S_DRAIN) && all_idle &&
                       (idle_cnt == IC_W'(IDLE_CYCLES - 1))) begin
            state  <= S_DONE;
            run    <= 1'b0;
            finish <= 1'b1;
            status <= 2'b01;
          end else if ((state == S_RUN) && test_done) begin
            state <= S_DRAIN;
          end
        end
        S_DONE: begin
          state <= S_DONE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_tb_ctrl.sv
// tb_axi_tb_ctrl: scoreboard bench for axi_tb_ctrl; each scenario pushes its
// expected end-of-test record, a monitor pops and compares on every finish.
module tb_axi_tb_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        test_done = 1'b0;
  logic [4:0]  ch_valid = '0;
  logic [4:0]  ch_ready = '0;
  logic        dut_rst;
  logic        run;
  logic [15:0] cycle_cnt;
  logic [15:0] xfer_cnt;
  logic        finish;
  logic [1:0]  status;
  logic [4:0]  stall_ch;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [1:0]  st;
    logic [4:0]  sch;
    logic [15:0] xfer;
    logic [15:0] cyc;
  } exp_t;

  exp_t exp_q[$];

  axi_tb_ctrl #(
    .NUM_CH(5),
    .RST_CYCLES(2),
    .TIMEOUT_CYCLES(100),
    .IDLE_CYCLES(16),
    .STALL_CYCLES(64),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .test_done(test_done),
    .ch_valid(ch_valid),
    .ch_ready(ch_ready),
    .dut_rst(dut_rst),
    .run(run),
    .cycle_cnt(cycle_cnt),
    .xfer_cnt(xfer_cnt),
    .finish(finish),
    .status(status),
    .stall_ch(stall_ch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every finish pulse must match the next queued expectation
  always @(negedge clk) begin
    if (finish) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_finish: got status %0h expected no finish at %0t", status, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_status", 32'(status), 32'(e.st));
        chk("sb_stall_ch", 32'(stall_ch), 32'(e.sch));
        chk("sb_xfer_cnt", 32'(xfer_cnt), 32'(e.xfer));
        chk("sb_cycle_cnt", 32'(cycle_cnt), 32'(e.cyc));
        chk("sb_run_low", 32'(run), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic [4:0] v, input logic [4:0] r, input logic td);
    ch_valid  = v;
    ch_ready  = r;
    test_done = td;
    tick();
  endtask

  task automatic do_reset();
    ch_valid  = '0;
    ch_ready  = '0;
    test_done = 1'b0;
    start     = 1'b0;
    rst       = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Start and check dut_rst held for two cycles, then run asserted
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rst_phase1", {30'd0, dut_rst, run}, 32'b10);
    tick();
    chk("rst_phase2", {30'd0, dut_rst, run}, 32'b10);
    tick();
    chk("run_entry", {30'd0, dut_rst, run}, 32'b01);
    chk("run_entry_cnt", 32'(cycle_cnt), 32'd0);
  endtask

  task automatic wait_finish();
    int n;
    n = 0;
    while (!finish && n < 200) begin
      tick();
      n++;
    end
    if (!finish) begin
      total++;
      bad++;
      $display("FAIL wait_finish: got no finish expected finish within 200 cycles at %0t", $time);
    end
  endtask

  task automatic after_done(input logic [1:0] st);
    tick();
    chk("finish_one_cycle", 32'(finish), 32'd0);
    chk("status_sticky", 32'(status), 32'(st));
  endtask

  task automatic basic_pass();
    exp_q.push_back('{st: 2'b01, sch: 5'b0, xfer: 16'd10, cyc: 16'd27});
    do_start();
    repeat (10) cyc(5'b00001, 5'b00001, 1'b0);
    cyc(5'b0, 5'b0, 1'b1);
    test_done = 1'b0;
    wait_finish();
    after_done(2'b01);
  endtask

  initial begin
    tick();
    tick();
    do_reset();
    chk("reset_dut_rst", 32'(dut_rst), 32'd1);
    chk("reset_run", 32'(run), 32'd0);
    chk("reset_counts", {cycle_cnt, xfer_cnt}, 32'd0);
    chk("reset_outs", {27'd0, finish, status, 2'b00} | 32'(stall_ch), 32'd0);

    // Basic pass
    basic_pass();

    // Drain restart: valid at idle count 15 pushes completion out
    do_reset();
    exp_q.push_back('{st: 2'b01, sch: 5'b0, xfer: 16'd1, cyc: 16'd33});
    do_start();
    cyc(5'b0, 5'b0, 1'b1);
    repeat (15) cyc(5'b0, 5'b0, 1'b0);
    cyc(5'b01000, 5'b01000, 1'b0);
    ch_valid = '0;
    ch_ready = '0;
    wait_finish();
    after_done(2'b01);

    // Timeout, then start ignored in DONE
    do_reset();
    exp_q.push_back('{st: 2'b10, sch: 5'b0, xfer: 16'd0, cyc: 16'd100});
    do_start();
    wait_finish();
    chk("timeout_run", 32'(run), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("done_ignores_start", {28'd0, status, dut_rst, run}, 32'b1000);
    chk("done_frozen_cnt", 32'(cycle_cnt), 32'd100);

    // Single-channel stall on ch1
    do_reset();
    exp_q.push_back('{st: 2'b11, sch: 5'b00010, xfer: 16'd0, cyc: 16'd64});
    do_start();
    ch_valid = 5'b00010;
    ch_ready = 5'b0;
    wait_finish();
    after_done(2'b11);

    // All channels handshake 4 cycles, then simultaneous stall ch1+ch4
    do_reset();
    exp_q.push_back('{st: 2'b11, sch: 5'b00010, xfer: 16'd20, cyc: 16'd68});
    do_start();
    repeat (4) cyc(5'b11111, 5'b11111, 1'b0);
    ch_valid = 5'b10010;
    ch_ready = 5'b0;
    wait_finish();

    // Stall and timeout coincide in cycle 100 (with test_done too)
    do_reset();
    exp_q.push_back('{st: 2'b11, sch: 5'b00100, xfer: 16'd0, cyc: 16'd100});
    do_start();
    repeat (36) cyc(5'b0, 5'b0, 1'b0);
    repeat (63) cyc(5'b00100, 5'b0, 1'b0);
    cyc(5'b00100, 5'b0, 1'b1);
    test_done = 1'b0;
    wait_finish();

    // Reset mid-run: no finish, counters cleared, clean rerun
    do_reset();
    do_start();
    repeat (7) cyc(5'b00001, 5'b00001, 1'b0);
    chk("midrun_xfer", 32'(xfer_cnt), 32'd7);
    ch_valid = '0;
    ch_ready = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrun_rst_state", {29'd0, dut_rst, run, finish}, 32'b100);
    chk("midrun_rst_cnt", {cycle_cnt, xfer_cnt}, 32'd0);
    chk("midrun_rst_status", 32'(status), 32'd0);
    repeat (5) tick();
    basic_pass();

    repeat (3) tick();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
